axil_slave_bridge: RTL and testbench
====================================

Name: axil_slave_bridge

Overview:
Parametrised AXI4-Lite slave that bridges host register accesses onto the coprocessor's simple request/done backend. It is the successor to the fixed 32-bit, 5-bit-address AXI slave front end. It adds:
- Configurable data/address width and register-window depth.
- Independent AW/W capture buffers.
- Out-of-range decode (DECERR).
- Fair read/write arbitration.
- An optional backend timeout.

Parameters:
ADDR_WIDTH, 8, AXI byte-address width.
DATA_WIDTH, 32, AXI/backend data width; legal values 32 or 64.
NUM_WORDS, 16, number of DATA_WIDTH-bit registers in the backend window; power of two, at least 2.
TIMEOUT_CYCLES, 64, backend wait limit in cycles (used only with AXIL_TIMEOUT_EN); at least 2.

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  reset
s_axi_awaddr  in  ADDR_WIDTH  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address ready
s_axi_wdata  in  DATA_WIDTH  write data
s_axi_wstrb  in  DATA_WIDTH/8  write byte strobes
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data ready
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  write response ready
s_axi_araddr  in  ADDR_WIDTH  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_rdata  out  DATA_WIDTH  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
write  out  1  backend write request, level
write_addrs  out  clog2(NUM_WORDS)  backend word index
write_data  out  DATA_WIDTH  backend write data
write_strobe  out  DATA_WIDTH/8  backend byte strobes
write_done  in  1  backend write complete
write_error  in  1  backend write failed
read  out  1  backend read request, level
read_addrs  out  clog2(NUM_WORDS)  backend word index
read_data  in  DATA_WIDTH  backend read data, valid with read_done
read_done  in  1  backend read complete
read_error  in  1  backend read failed

Behaviour:
Clock, reset and reset values
- Single clock s_axi_aclk. Reset s_axi_aresetn is synchronous and active-low.
- During and after reset, all outputs are 0 except the ready signals. s_axi_awready, s_axi_wready and s_axi_arready are 0 while reset is asserted and 1 on the first cycle after release.

Capture buffers
- Three one-entry buffers: AW, W and AR. Each ready signal equals NOT(buffer full).
- A handshake loads its buffer.
- AW and W are accepted in either order, or in the same cycle.

Decode
- Word index = addr >> log2(DATA_WIDTH/8). Low address bits are ignored.
- Index >= NUM_WORDS is out of range:
  - No backend request is issued.
  - Response is DECERR (2'b11) one cycle after grant.
  - s_axi_rdata is 0 on an out-of-range read.

FSM states: IDLE, WR_BUSY, WR_RESP, RD_BUSY, RD_RESP.
- IDLE, write pending: a write is pending when both the AW and W buffers are full. Grant a pending write by moving to WR_BUSY, or to WR_RESP if out of range.
- IDLE, read pending: a read is pending when the AR buffer is full. Grant it the same way, to RD_BUSY or RD_RESP.
- IDLE, both pending: alternate grants, using a last-grant flag. The first grant after reset goes to the write.
- Freeing buffers: granted buffers are emptied on the grant edge, so the next request may be accepted while the current one completes.
- WR_BUSY / RD_BUSY: write (or read) is high. write_addrs, write_data and write_strobe (or read_addrs) are stable for the whole state.
  - done or error sampled high ends the state.
  - error has priority over done: response is SLVERR (2'b10), otherwise OKAY (2'b00).
  - read_data is registered into s_axi_rdata when read_done is sampled. On read_error, s_axi_rdata is 0.
  - done and error inputs are ignored outside the BUSY states.
- WR_RESP / RD_RESP: bvalid (or rvalid) is held, with bresp, rresp and rdata stable, until bready (or rready). After that handshake, return to IDLE.
- Only one transaction is in flight at a time.

Latency
- If AW and W both handshake in cycle N, write goes high in N+2.
- If write_done is high in that cycle, bvalid goes high in N+3.
- Reads have the same timing.

Reset mid-operation: return to IDLE, drop write/read, clear all buffers and valids. The in-flight transaction is discarded with no response.

Optional Feature:
AXIL_TIMEOUT_EN
- Defined: a counter clears on entry to a BUSY state and increments each BUSY cycle.
  - If TIMEOUT_CYCLES cycles elapse without done or error, drop the request and respond SLVERR, with rdata 0.
  - If done arrives in the same cycle as expiry, done wins.
- Not defined: no counter is built, and the bridge waits indefinitely for done or error.

Test Plan:
Use DATA_WIDTH=32, NUM_WORDS=8, TIMEOUT_CYCLES=16.
- Write with W before AW: W 0x0000007B, strb 4'hF in cycle 0; AW 0x0C in cycle 2. -> write_addrs=3, write_data=0x7B for exactly the cycles write is high; write_done -> bresp=00, bvalid held until bready.
- Read with error: read 0x10 with backend read_data 0x4D2 and read_done. -> read_addrs=4, rdata=0x000004D2, rresp=00. Read 0x14 with read_error=1. -> rresp=10, rdata=0.
- Out-of-range decode: write 0x20 and read 0x3C. -> write and read never asserted; bresp=11, rresp=11, rdata=0.
- Simultaneous requests: AW, W and AR all presented in the same cycle, twice back-to-back. -> grant order is W, R, W, R; no overlap between write and read.
- Timeout: backend never responds, with AXIL_TIMEOUT_EN defined. -> write drops after 16 cycles, bresp=10. With the macro undefined, bvalid stays 0 for 100 cycles.
- Reset mid-operation: s_axi_aresetn low while in RD_BUSY. -> next cycle read=0 and rvalid=0; all readys 0 during reset and 1 after release.

Source files
------------

// File: rtl/axil_slave_bridge.sv
// axil_slave_bridge: AXI4-Lite slave that forwards register accesses onto the coprocessor request/done backend.
// Define AXIL_TIMEOUT_EN to bound each backend wait to TIMEOUT_CYCLES cycles (SLVERR on expiry).
module axil_slave_bridge #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 32,
   parameter int NUM_WORDS      = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                          s_axi_aclk,
   input  logic                          s_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]         s_axi_awaddr,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [DATA_WIDTH-1:0]         s_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]       s_axi_wstrb,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   output logic [1:0]                    s_axi_bresp,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   input  logic [ADDR_WIDTH-1:0]         s_axi_araddr,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   output logic [DATA_WIDTH-1:0]         s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready,
   output logic                          write,
   output logic [$clog2(NUM_WORDS)-1:0]  write_addrs,
   output logic [DATA_WIDTH-1:0]         write_data,
   output logic [DATA_WIDTH/8-1:0]       write_strobe,
   input  logic                          write_done,
   input  logic                          write_error,
   output logic                          read,
   output logic [$clog2(NUM_WORDS)-1:0]  read_addrs,
   input  logic [DATA_WIDTH-1:0]         read_data,
   input  logic                          read_done,
   input  logic                          read_error
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int IDX_WIDTH  = $clog2(NUM_WORDS);
   localparam int LSB        = $clog2(STRB_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] WORD_LIMIT = ADDR_WIDTH'(NUM_WORDS);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_BUSY = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD_BUSY = 3'd3;
   localparam logic [2:0] RD_RESP = 3'd4;

   logic [2:0]            state;
   logic                  last_wr;
   logic                  tmo_hit;

   logic                  aw_full, aw_oor;
   logic [IDX_WIDTH-1:0]  aw_idx;
   logic                  w_full;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [STRB_WIDTH-1:0] w_strb_q;
   logic                  ar_full, ar_oor;
   logic [IDX_WIDTH-1:0]  ar_idx;

   logic [ADDR_WIDTH-1:0] aw_word, ar_word;
   logic                  grant_wr, grant_rd;

   assign aw_word = s_axi_awaddr >> LSB;
   assign ar_word = s_axi_araddr >> LSB;

   // Ready is gated by reset so the master sees 0 for the whole reset window.
   assign s_axi_awready = s_axi_aresetn & ~aw_full;
   assign s_axi_wready  = s_axi_aresetn & ~w_full;
   assign s_axi_arready = s_axi_aresetn & ~ar_full;

   // A read wins a tie only when the previous grant went to a write.
   assign grant_wr = (state == IDLE) & aw_full & w_full & (~ar_full | ~last_wr);
   assign grant_rd = (state == IDLE) & ar_full & ~grant_wr;

   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         aw_full <= 1'b0;
         w_full  <= 1'b0;
         ar_full <= 1'b0;
      end else begin
         if (s_axi_awvalid && s_axi_awready) aw_full <= 1'b1;
         else if (grant_wr)                  aw_full <= 1'b0;
         if (s_axi_wvalid && s_axi_wready)   w_full  <= 1'b1;
         else if (grant_wr)                  w_full  <= 1'b0;
         if (s_axi_arvalid && s_axi_arready) ar_full <= 1'b1;
         else if (grant_rd)                  ar_full <= 1'b0;
      end
   end

   // Decode happens at capture so the grant path only looks at one flag.
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_awvalid && s_axi_awready) begin
         aw_idx <= aw_word[IDX_WIDTH-1:0];
         aw_oor <= (aw_word >= WORD_LIMIT);
      end
      if (s_axi_wvalid && s_axi_wready) begin
         w_data_q <= s_axi_wdata;
         w_strb_q <= s_axi_wstrb;
      end
      if (s_axi_arvalid && s_axi_arready) begin
         ar_idx <= ar_word[IDX_WIDTH-1:0];
         ar_oor <= (ar_word >= WORD_LIMIT);
      end
   end

`ifdef AXIL_TIMEOUT_EN
   localparam int TMO_WIDTH = $clog2(TIMEOUT_CYCLES);
   logic [TMO_WIDTH-1:0] tmo_cnt;

   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn || (state != WR_BUSY && state != RD_BUSY)) tmo_cnt <= '0;
      else                                                         tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo_hit = (tmo_cnt == TMO_WIDTH'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge s_axi_aclk) begin
      if (!s_axi_aresetn) begin
         state        <= IDLE;
         last_wr      <= 1'b0;
         write        <= 1'b0;
         write_addrs  <= '0;
         write_data   <= '0;
         write_strobe <= '0;
         read         <= 1'b0;
         read_addrs   <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
         s_axi_rvalid <= 1'b0;
         s_axi_rresp  <= RESP_OKAY;
         s_axi_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_wr) begin
                  last_wr <= 1'b1;
                  if (aw_oor) begin
                     s_axi_bresp  <= RESP_DECERR;
                     s_axi_bvalid <= 1'b1;
                     state        <= WR_RESP;
                  end else begin
                     write        <= 1'b1;
                     write_addrs  <= aw_idx;
                     write_data   <= w_data_q;
                     write_strobe <= w_strb_q;
                     state        <= WR_BUSY;
                  end
               end else if (grant_rd) begin
                  last_wr <= 1'b0;
                  if (ar_oor) begin
                     s_axi_rresp  <= RESP_DECERR;
                     s_axi_rdata  <= '0;
                     s_axi_rvalid <= 1'b1;
                     state        <= RD_RESP;
                  end else begin
                     read       <= 1'b1;
                     read_addrs <= ar_idx;
                     state      <= RD_BUSY;
                  end
               end
            end
            WR_BUSY: begin
               if (write_error || write_done || tmo_hit) begin
                  write        <= 1'b0;
                  s_axi_bvalid <= 1'b1;
                  s_axi_bresp  <= (write_done && !write_error) ? RESP_OKAY : RESP_SLVERR;
                  state        <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid <= 1'b0;
                  state        <= IDLE;
               end
            end
            RD_BUSY: begin
               if (read_error || read_done || tmo_hit) begin
                  read         <= 1'b0;
                  s_axi_rvalid <= 1'b1;
                  if (read_done && !read_error) begin
                     s_axi_rresp <= RESP_OKAY;
                     s_axi_rdata <= read_data;
                  end else begin
                     s_axi_rresp <= RESP_SLVERR;
                     s_axi_rdata <= '0;
                  end
                  state <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (s_axi_rready) begin
                  s_axi_rvalid <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_slave_bridge.sv
// tb_axil_slave_bridge: directed scoreboard bench for axil_slave_bridge (32-bit data, 8 words, timeout 16).
// Honours AXIL_TIMEOUT_EN the same way the design does.
module tb_axil_slave_bridge;

   typedef struct {
      bit          is_wr;
      logic [2:0]  idx;
      logic [31:0] data;
      logic [3:0]  strb;
      int          cycles;
   } be_req_t;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
   } r_exp_t;

   logic        s_axi_aclk;
   logic        s_axi_aresetn;
   logic [7:0]  s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [7:0]  s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic        write;
   logic [2:0]  write_addrs;
   logic [31:0] write_data;
   logic [3:0]  write_strobe;
   logic        write_done;
   logic        write_error;
   logic        read;
   logic [2:0]  read_addrs;
   logic [31:0] read_data;
   logic        read_done;
   logic        read_error;

   be_req_t     be_exp[$];
   logic [1:0]  exp_b[$];
   r_exp_t      exp_r[$];

   int          n_checks = 0;
   int          n_fail   = 0;

   int          be_wr_delay = 0;
   bit          be_wr_err   = 0;
   bit          be_wr_hang  = 0;
   int          be_rd_delay = 0;
   bit          be_rd_err   = 0;
   bit          be_rd_hang  = 0;
   logic [31:0] be_rd_value = 32'h0;

   axil_slave_bridge #(
      .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_WORDS(8), .TIMEOUT_CYCLES(16)
   ) dut (
      .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .write(write), .write_addrs(write_addrs), .write_data(write_data), .write_strobe(write_strobe),
      .write_done(write_done), .write_error(write_error),
      .read(read), .read_addrs(read_addrs), .read_data(read_data),
      .read_done(read_done), .read_error(read_error)
   );

   initial s_axi_aclk = 1'b0;
   always #5 s_axi_aclk = ~s_axi_aclk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   task automatic expectWrite(input logic [2:0] idx, input logic [31:0] data, input logic [3:0] strb, input int cycles);
      be_req_t e;
      e.is_wr = 1'b1; e.idx = idx; e.data = data; e.strb = strb; e.cycles = cycles;
      be_exp.push_back(e);
   endtask

   task automatic expectRead(input logic [2:0] idx, input int cycles);
      be_req_t e;
      e.is_wr = 1'b0; e.idx = idx; e.data = 32'h0; e.strb = 4'h0; e.cycles = cycles;
      be_exp.push_back(e);
   endtask

   task automatic expectR(input logic [1:0] resp, input logic [31:0] data);
      r_exp_t e;
      e.resp = resp; e.data = data;
      exp_r.push_back(e);
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge s_axi_aclk);
      #1;
   endtask

   // Present the selected channels together; each valid drops after its own handshake.
   task automatic applyStimulus(input bit do_aw, input logic [7:0] aw_addr,
                                input bit do_w, input logic [31:0] wdata, input logic [3:0] wstrb,
                                input bit do_ar, input logic [7:0] ar_addr);
      bit aw_hs, w_hs, ar_hs;
      s_axi_awaddr  = aw_addr;
      s_axi_wdata   = wdata;
      s_axi_wstrb   = wstrb;
      s_axi_araddr  = ar_addr;
      s_axi_awvalid = do_aw;
      s_axi_wvalid  = do_w;
      s_axi_arvalid = do_ar;
      for (int c = 0; c < 200 && (s_axi_awvalid || s_axi_wvalid || s_axi_arvalid); c++) begin
         @(negedge s_axi_aclk);
         aw_hs = s_axi_awvalid && s_axi_awready;
         w_hs  = s_axi_wvalid && s_axi_wready;
         ar_hs = s_axi_arvalid && s_axi_arready;
         @(posedge s_axi_aclk);
         #1;
         if (aw_hs) s_axi_awvalid = 1'b0;
         if (w_hs)  s_axi_wvalid  = 1'b0;
         if (ar_hs) s_axi_arvalid = 1'b0;
      end
      checkOutput("handshake_done", {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid}, 3'b000);
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      s_axi_arvalid = 1'b0;
   endtask

   task automatic waitDrain(input string name);
      int c;
      c = 0;
      while (c < 300 && (exp_b.size() + exp_r.size() + be_exp.size()) != 0) begin
         @(posedge s_axi_aclk);
         #1;
         c++;
      end
      checkOutput(name, exp_b.size() + exp_r.size() + be_exp.size(), 0);
      waitCycles(1);
   endtask

   // Backend responder: answers after be_*_delay extra cycles unless hung.
   initial begin
      int wcnt, rcnt;
      wcnt = 0; rcnt = 0;
      write_done = 1'b0; write_error = 1'b0;
      read_done  = 1'b0; read_error  = 1'b0;
      read_data  = 32'h0;
      forever begin
         @(posedge s_axi_aclk);
         #1;
         write_done = 1'b0; write_error = 1'b0;
         read_done  = 1'b0; read_error  = 1'b0;
         read_data  = be_rd_value;
         if (write === 1'b1 && !be_wr_hang) begin
            if (wcnt >= be_wr_delay) begin
               write_done = !be_wr_err; write_error = be_wr_err; wcnt = 0;
            end else wcnt++;
         end else wcnt = 0;
         if (read === 1'b1 && !be_rd_hang) begin
            if (rcnt >= be_rd_delay) begin
               read_done = !be_rd_err; read_error = be_rd_err; rcnt = 0;
            end else rcnt++;
         end else rcnt = 0;
      end
   end

   // Backend request monitor: grant order, request fields, stability and request length.
   initial begin
      bit      prev_w, prev_r;
      be_req_t cur_w, cur_r;
      int      wcyc, rcyc;
      prev_w = 0; prev_r = 0; wcyc = 0; rcyc = 0;
      cur_w.cycles = 0; cur_r.cycles = 0;
      forever begin
         @(negedge s_axi_aclk);
         if (write === 1'b1 || read === 1'b1) checkOutput("req_overlap", write & read, 0);
         if (write === 1'b1) begin
            if (!prev_w) begin
               checkOutput("write_req_expected", be_exp.size() != 0, 1);
               if (be_exp.size() != 0) begin
                  cur_w = be_exp.pop_front();
                  checkOutput("grant_kind_w", {write, read}, {cur_w.is_wr, !cur_w.is_wr});
               end else begin
                  cur_w.idx = write_addrs; cur_w.data = write_data; cur_w.strb = write_strobe; cur_w.cycles = 0;
               end
               wcyc = 0;
            end
            checkOutput("write_addrs", write_addrs, cur_w.idx);
            checkOutput("write_data", write_data, cur_w.data);
            checkOutput("write_strobe", write_strobe, cur_w.strb);
            wcyc++;
         end else if (prev_w && cur_w.cycles != 0) begin
            checkOutput("write_cycles", wcyc, cur_w.cycles);
         end
         if (read === 1'b1) begin
            if (!prev_r) begin
               checkOutput("read_req_expected", be_exp.size() != 0, 1);
               if (be_exp.size() != 0) begin
                  cur_r = be_exp.pop_front();
                  checkOutput("grant_kind_r", {write, read}, {cur_r.is_wr, !cur_r.is_wr});
               end else begin
                  cur_r.idx = read_addrs; cur_r.cycles = 0;
               end
               rcyc = 0;
            end
            checkOutput("read_addrs", read_addrs, cur_r.idx);
            rcyc++;
         end else if (prev_r && cur_r.cycles != 0) begin
            checkOutput("read_cycles", rcyc, cur_r.cycles);
         end
         prev_w = (write === 1'b1);
         prev_r = (read === 1'b1);
      end
   end

   // Response scoreboard: compare on every B/R handshake.
   initial begin
      logic [1:0] eb;
      r_exp_t     er;
      forever begin
         @(negedge s_axi_aclk);
         if (s_axi_bvalid === 1'b1 && s_axi_bready) begin
            checkOutput("b_expected", exp_b.size() != 0, 1);
            if (exp_b.size() != 0) begin
               eb = exp_b.pop_front();
               checkOutput("bresp", s_axi_bresp, eb);
            end
         end
         if (s_axi_rvalid === 1'b1 && s_axi_rready) begin
            checkOutput("r_expected", exp_r.size() != 0, 1);
            if (exp_r.size() != 0) begin
               er = exp_r.pop_front();
               checkOutput("rresp", s_axi_rresp, er.resp);
               checkOutput("rdata", s_axi_rdata, er.data);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c;
      bit saw;
      s_axi_aresetn = 1'b0;
      s_axi_awaddr = 8'h0; s_axi_awvalid = 1'b0;
      s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0; s_axi_wvalid = 1'b0;
      s_axi_araddr = 8'h0; s_axi_arvalid = 1'b0;
      s_axi_bready = 1'b1; s_axi_rready = 1'b1;

      repeat (3) @(posedge s_axi_aclk);
      @(negedge s_axi_aclk);
      checkOutput("rst_readys", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
      checkOutput("rst_valids", {s_axi_bvalid, s_axi_rvalid, write, read}, 4'b0000);
      checkOutput("rst_resp_data", {s_axi_bresp, s_axi_rresp, s_axi_rdata}, 36'h0);
      @(posedge s_axi_aclk); #1;
      s_axi_aresetn = 1'b1;
      @(negedge s_axi_aclk);
      checkOutput("readys_after_reset", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
      waitCycles(1);

      $display("[TB] W before AW, response held until bready");
      s_axi_bready = 1'b0;
      be_wr_delay = 2;
      expectWrite(3'd3, 32'h7B, 4'hF, 3);
      exp_b.push_back(2'b00);
      applyStimulus(0, 8'h00, 1, 32'h7B, 4'hF, 0, 8'h00);
      waitCycles(2);
      checkOutput("no_write_before_aw", write, 1'b0);
      applyStimulus(1, 8'h0C, 0, 32'h0, 4'h0, 0, 8'h00);
      c = 0;
      while (c < 50 && s_axi_bvalid !== 1'b1) begin waitCycles(1); c++; end
      checkOutput("bvalid_arrives", s_axi_bvalid, 1'b1);
      repeat (4) begin
         @(negedge s_axi_aclk);
         checkOutput("bvalid_held", s_axi_bvalid, 1'b1);
         checkOutput("bresp_held", s_axi_bresp, 2'b00);
      end
      waitCycles(1);
      s_axi_bready = 1'b1;
      waitDrain("drain_w_before_aw");

      $display("[TB] write latency");
      be_wr_delay = 0;
      expectWrite(3'd1, 32'h0000A5A5, 4'h3, 1);
      exp_b.push_back(2'b00);
      applyStimulus(1, 8'h04, 1, 32'h0000A5A5, 4'h3, 0, 8'h00);
      checkOutput("lat_write_n1", write, 1'b0);
      waitCycles(1);
      checkOutput("lat_write_n2", write, 1'b1);
      waitCycles(1);
      checkOutput("lat_bvalid_n3", s_axi_bvalid, 1'b1);
      waitDrain("drain_latency");

      $display("[TB] reads, read error, write error");
      be_rd_delay = 1;
      be_rd_value = 32'h4D2;
      expectRead(3'd4, 2);
      expectR(2'b00, 32'h000004D2);
      applyStimulus(0, 8'h00, 0, 32'h0, 4'h0, 1, 8'h10);
      waitDrain("drain_read_ok");
      be_rd_err = 1;
      expectRead(3'd5, 2);
      expectR(2'b10, 32'h0);
      applyStimulus(0, 8'h00, 0, 32'h0, 4'h0, 1, 8'h14);
      waitDrain("drain_read_err");
      be_rd_err = 0;
      be_wr_err = 1;
      expectWrite(3'd0, 32'hDEAD, 4'hF, 1);
      exp_b.push_back(2'b10);
      applyStimulus(1, 8'h00, 1, 32'hDEAD, 4'hF, 0, 8'h00);
      waitDrain("drain_write_err");
      be_wr_err = 0;

      $display("[TB] out-of-range decode");
      be_rd_value = 32'h12345678;
      exp_b.push_back(2'b11);
      applyStimulus(1, 8'h20, 1, 32'h55, 4'hF, 0, 8'h00);
      waitDrain("drain_oor_write");
      expectR(2'b11, 32'h0);
      applyStimulus(0, 8'h00, 0, 32'h0, 4'h0, 1, 8'h3C);
      waitDrain("drain_oor_read");

      $display("[TB] simultaneous requests");
      be_wr_delay = 1;
      be_rd_value = 32'hCAFE;
      expectWrite(3'd2, 32'h111, 4'hF, 2);
      expectRead(3'd6, 2);
      expectWrite(3'd7, 32'h222, 4'hF, 2);
      expectRead(3'd0, 2);
      exp_b.push_back(2'b00);
      exp_b.push_back(2'b00);
      expectR(2'b00, 32'hCAFE);
      expectR(2'b00, 32'hCAFE);
      applyStimulus(1, 8'h08, 1, 32'h111, 4'hF, 1, 8'h18);
      applyStimulus(1, 8'h1C, 1, 32'h222, 4'hF, 1, 8'h00);
      waitDrain("drain_simultaneous");

      $display("[TB] unresponsive backend");
      be_wr_hang = 1;
`ifdef AXIL_TIMEOUT_EN
      expectWrite(3'd5, 32'h99, 4'hF, 16);
      exp_b.push_back(2'b10);
      applyStimulus(1, 8'h14, 1, 32'h99, 4'hF, 0, 8'h00);
      waitDrain("drain_timeout");
      be_wr_hang = 0;
`else
      expectWrite(3'd5, 32'h99, 4'hF, 0);
      applyStimulus(1, 8'h14, 1, 32'h99, 4'hF, 0, 8'h00);
      saw = 0;
      repeat (100) begin
         @(negedge s_axi_aclk);
         if (s_axi_bvalid === 1'b1) saw = 1;
      end
      checkOutput("no_bvalid_while_waiting", saw, 1'b0);
      exp_b.push_back(2'b00);
      waitCycles(1);
      be_wr_hang = 0;
      waitDrain("drain_late_done");
`endif

      $display("[TB] reset during read");
      be_rd_hang = 1;
      expectRead(3'd3, 0);
      applyStimulus(0, 8'h00, 0, 32'h0, 4'h0, 1, 8'h0C);
      c = 0;
      while (c < 20 && read !== 1'b1) begin waitCycles(1); c++; end
      checkOutput("read_busy_reached", read, 1'b1);
      s_axi_aresetn = 1'b0;
      waitCycles(1);
      checkOutput("midrst_read_rvalid", {read, s_axi_rvalid}, 2'b00);
      checkOutput("midrst_readys", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
      waitCycles(1);
      s_axi_aresetn = 1'b1;
      be_rd_hang = 0;
      @(negedge s_axi_aclk);
      checkOutput("midrst_readys_release", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
      checkOutput("midrst_no_rvalid", s_axi_rvalid, 1'b0);
      waitCycles(1);
      expectRead(3'd2, 2);
      expectR(2'b00, 32'hCAFE);
      applyStimulus(0, 8'h00, 0, 32'h0, 4'h0, 1, 8'h08);
      waitDrain("drain_after_reset");

      checkOutput("queues_empty", exp_b.size() + exp_r.size() + be_exp.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
